// File: rtl/ps2_rx_frame_reader_if.sv
// Signal bundle between the PS/2 communication controller and the frame reader.
// The controller arms the reader and drives the lines; the reader reports the frame.
interface ps2_rx_frame_reader_if;
    logic        enable;
    logic [7:0]  to_limit;
    logic        ps2c_in;
    logic        ps2d_in;
    logic        reading;
    logic [10:0] data;
    logic        done;
    logic        err;

    modport master (
        output enable, to_limit, ps2c_in, ps2d_in,
        input  reading, data, done, err
    );

    modport slave (
        input  enable, to_limit, ps2c_in, ps2d_in,
        output reading, data, done, err
    );
endinterface

// File: rtl/ps2_rx_frame_reader.sv
// PS/2 device-to-host frame receiver: ticked line sampler, one-shot inactivity
// watchdog and a capture FSM reporting an 11-bit frame with done/err status.
module ps2_rx_frame_reader #(
    parameter int unsigned DIV_PERIOD = 200,
    parameter int unsigned TO_PERIOD  = 2500
) (
    input logic                qzt_clk,
    input logic                rst,
    ps2_rx_frame_reader_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WAIT, RECV, CHECK} state_t;

    localparam logic [29:0] DIV_LAST = 30'(DIV_PERIOD - 1);
    localparam logic [29:0] TO_LAST  = 30'(TO_PERIOD - 1);

    state_t      state, state_n;
    logic [29:0] div_cnt, to_cnt;
    logic        tick, to_tick;
    logic        c_meta, c_sync, d_meta, d_sync, c_samp;
    logic        fall, run, expire;
    logic [7:0]  wd_cnt;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [10:0] data_q, data_n;
    logic        done_q, done_n, err_q, err_n, reading_q, reading_n;

    assign tick    = (div_cnt == DIV_LAST);
    assign to_tick = (to_cnt == TO_LAST);
    // c_samp holds the previous tick's sample; c_sync is the one being taken now.
    assign fall    = tick && c_samp && !c_sync;
    assign run     = (state == RECV);
    assign expire  = run && (bus.to_limit != 8'd0) && (wd_cnt == bus.to_limit);

    always_ff @(posedge qzt_clk) begin
        if (rst) begin
            div_cnt <= '0;
            to_cnt  <= '0;
            c_meta  <= 1'b1;
            c_sync  <= 1'b1;
            d_meta  <= 1'b1;
            d_sync  <= 1'b1;
            c_samp  <= 1'b1;
        end else begin
            div_cnt <= tick    ? '0 : div_cnt + 30'd1;
            to_cnt  <= to_tick ? '0 : to_cnt + 30'd1;
            c_meta  <= bus.ps2c_in;
            c_sync  <= c_meta;
            d_meta  <= bus.ps2d_in;
            d_sync  <= d_meta;
            if (tick)
                c_samp <= c_sync;
        end
    end

    // Watchdog restarts on every falling edge and freezes once it has expired.
    always_ff @(posedge qzt_clk) begin
        if (rst || !run || fall)
            wd_cnt <= '0;
        else if (to_tick && !expire)
            wd_cnt <= wd_cnt + 8'd1;
    end

    always_ff @(posedge qzt_clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            reading_q <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            data_q    <= data_n;
            done_q    <= done_n;
            err_q     <= err_n;
            reading_q <= reading_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        data_n    = data_q;
        done_n    = done_q;
        err_n     = err_q;
        if (!bus.enable) begin
            state_n = IDLE;
            done_n  = 1'b0;
            err_n   = 1'b0;
        end else begin
            case (state)
                IDLE: state_n = WAIT;
                WAIT: begin
                    if (fall) begin
                        data_n    = {10'b0, d_sync};
                        bit_cnt_n = 4'd1;
                        done_n    = 1'b0;
                        err_n     = 1'b0;
                        state_n   = RECV;
                    end
                end
                RECV: begin
                    if (fall) begin
                        data_n[bit_cnt] = d_sync;
                        bit_cnt_n       = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd10)
                            state_n = CHECK;
                    end else if (expire) begin
                        err_n   = 1'b1;
                        done_n  = 1'b1;
                        state_n = WAIT;
                    end
                end
                CHECK: begin
                    err_n   = data_q[0] | ~data_q[10] | ~(^data_q[9:1]);
                    done_n  = 1'b1;
                    state_n = WAIT;
                end
                default: state_n = IDLE;
            endcase
        end
        // Registered so it drops on the same edge that raises done.
        reading_n = (state_n == RECV) || (state_n == CHECK);
    end

    assign bus.reading = reading_q;
    assign bus.data    = data_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_ps2_rx_frame_reader.sv
// Self-checking bench for ps2_rx_frame_reader: frames are driven onto the lines,
// expected results are queued from a frame-level model and checked when done rises.
module tb_ps2_rx_frame_reader;

    localparam int DIV = 4;
    localparam int TO  = 8;

    typedef struct {
        logic [10:0] data;
        logic        err;
    } exp_t;

    logic qzt_clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic done_prev = 1'b0;

    ps2_rx_frame_reader_if bus();

    ps2_rx_frame_reader #(.DIV_PERIOD(DIV), .TO_PERIOD(TO)) dut (
        .qzt_clk (qzt_clk),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 qzt_clk = ~qzt_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Frame on the wire: start 0, byte LSB first, parity, stop 1.
    function automatic logic [10:0] frameWord(input logic [7:0] b, input logic par);
        return {1'b1, par, b, 1'b0};
    endfunction

    // A well-formed frame has an odd number of ones across byte and parity.
    function automatic logic frameBad(input logic [7:0] b, input logic par);
        return ((($countones(b) + int'(par)) % 2) == 0);
    endfunction

    task automatic pushExpect(input logic [10:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.err  = e;
        exp_q.push_back(x);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge qzt_clk);
        #1;
    endtask

    task automatic sendBit(input logic d, input int half);
        bus.ps2d_in = d;
        cycles(half / 2);
        bus.ps2c_in = 1'b0;
        cycles(half);
        bus.ps2c_in = 1'b1;
        cycles(half - half / 2);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic par,
                                 input int first, input int last, input int half);
        logic [10:0] w;
        w = frameWord(b, par);
        for (int i = first; i <= last; i++) begin
            sendBit(w[i], half);
            if (i == 0) begin
                checkOutput("reading_after_start", bus.reading, 1);
                checkOutput("done_cleared_by_start", bus.done, 0);
            end
        end
    endtask

    task automatic waitDone(input int budget, output int waited);
        waited = 0;
        while (!bus.done && waited < budget) begin
            @(negedge qzt_clk);
            waited++;
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: actual done=0 required done=1 within %0d cycles", budget);
        end
    endtask

    // Monitor: every rising edge of done consumes one expected frame.
    always @(negedge qzt_clk) begin
        exp_t e;
        if (bus.done === 1'b1 && done_prev === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: actual data=0x%0h err=%0b required no done",
                         bus.data, bus.err);
            end else begin
                e = exp_q.pop_front();
                checkOutput("frame_data", bus.data, e.data);
                checkOutput("frame_err", bus.err, e.err);
                checkOutput("reading_at_done", bus.reading, 0);
            end
        end
        done_prev = bus.done;
    end

    initial begin
        int w;
        logic [7:0] b;
        logic p;
        int half;

        rst = 1'b1;
        bus.enable = 1'b0;
        bus.to_limit = 8'd0;
        bus.ps2c_in = 1'b1;
        bus.ps2d_in = 1'b1;
        cycles(3);
        checkOutput("reset_reading", bus.reading, 0);
        checkOutput("reset_data", bus.data, 0);
        checkOutput("reset_done", bus.done, 0);
        checkOutput("reset_err", bus.err, 0);
        rst = 1'b0;
        bus.enable = 1'b1;
        bus.to_limit = 8'd200;
        cycles(5);

        $display("[TB] good frame 0xFA");
        pushExpect(11'h7F4, 1'b0);
        applyStimulus(8'hFA, 1'b1, 0, 10, 20);
        waitDone(100, w);
        cycles(10);

        $display("[TB] bad parity frame 0xFA");
        pushExpect(11'h5F4, 1'b1);
        applyStimulus(8'hFA, 1'b0, 0, 10, 20);
        waitDone(100, w);
        cycles(10);

        $display("[TB] watchdog timeout after 5 bits");
        bus.to_limit = 8'd3;
        b = 8'($urandom);
        p = 1'($urandom);
        pushExpect(frameWord(b, p) & 11'h01F, 1'b1);
        applyStimulus(b, p, 0, 4, 8);
        waitDone(100, w);
        checkOutput("timeout_latency_in_window", ((w + 12) >= 18 && (w + 12) <= 36), 1);
        checkOutput("timeout_reading_low", bus.reading, 0);
        cycles(10);

        $display("[TB] long stall with watchdog disabled");
        bus.to_limit = 8'd0;
        pushExpect(11'h600, 1'b0);
        applyStimulus(8'h00, 1'b1, 0, 4, 20);
        cycles(10000);
        applyStimulus(8'h00, 1'b1, 5, 10, 20);
        waitDone(100, w);
        cycles(10);

        $display("[TB] enable dropped mid-frame");
        applyStimulus(8'h55, 1'b1, 0, 3, 20);
        bus.enable = 1'b0;
        cycles(1);
        checkOutput("disable_reading", bus.reading, 0);
        checkOutput("disable_done", bus.done, 0);
        checkOutput("disable_err", bus.err, 0);
        cycles(5);
        bus.enable = 1'b1;
        cycles(5);
        pushExpect(11'h754, 1'b0);
        applyStimulus(8'hAA, 1'b1, 0, 10, 20);
        waitDone(100, w);
        cycles(10);

        $display("[TB] reset mid-frame");
        applyStimulus(8'h3C, 1'b0, 0, 2, 20);
        rst = 1'b1;
        cycles(1);
        checkOutput("midreset_reading", bus.reading, 0);
        checkOutput("midreset_data", bus.data, 0);
        checkOutput("midreset_done", bus.done, 0);
        checkOutput("midreset_err", bus.err, 0);
        rst = 1'b0;
        cycles(200);
        b = 8'($urandom);
        p = 1'($urandom);
        pushExpect(frameWord(b, p), frameBad(b, p));
        applyStimulus(b, p, 0, 10, 20);
        waitDone(100, w);
        cycles(10);

        $display("[TB] randomized frames");
        for (int n = 0; n < 8; n++) begin
            b = 8'($urandom);
            p = 1'($urandom);
            half = int'($urandom_range(30, 12));
            bus.to_limit = ($urandom_range(1, 0) == 0) ? 8'd0 : 8'($urandom_range(255, 10));
            pushExpect(frameWord(b, p), frameBad(b, p));
            applyStimulus(b, p, 0, 10, half);
            waitDone(100, w);
            cycles(int'($urandom_range(20, 5)));
        end

        cycles(20);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_rx_frame_reader.md
# ps2_rx_frame_reader

PS/2 device-to-host frame receiver with a built-in sample-tick divider and a single-shot 8-bit inactivity watchdog. It captures one 11-bit frame (start, 8 data LSB-first, odd parity, stop) from the PS2C/PS2D lines while enabled, then reports the frame, completion and error status. It sits under the PS/2 communication controller, which enables it after a command has been sent and waits for `done`.

## Interface
- `DIV_PERIOD`, 200: qzt_clk cycles per line-sample tick (divider output); legal range 2..2^30-1.
- `TO_PERIOD`, 2500: qzt_clk cycles per watchdog tick; legal range 2..2^30-1.
- `qzt_clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  level; high = receiver armed, low = abort and idle.
- `to_limit`  in  8  watchdog limit in watchdog ticks; 0 disables the watchdog.
- `ps2c_in`  in  1  PS/2 clock line (read only; block never drives lines).
- `ps2d_in`  in  1  PS/2 data line (read only).
- `reading`  out  1  high while a frame is in progress.
- `data`  out  11  last frame; `data[0]`=start, `data[8:1]`=byte, `data[9]`=parity, `data[10]`=stop.
- `done`  out  1  frame finished (good or bad); level.
- `err`  out  1  qualifies `done`: frame bad or timed out; level.

## Operation
- Divider: free-running counter 0..DIV_PERIOD-1; one-cycle `tick` when it wraps. Same structure for the watchdog tick (TO_PERIOD). Both counters run regardless of `enable`.
- Line inputs pass through a 2-flop synchronizer on qzt_clk, then are sampled only on `tick`. Falling edge = previous sample 1, current sample 0 (both taken on ticks).
- Watchdog (one-run counter): 8-bit count cleared while `run`=0 and on every detected falling edge; while `run`=1 increments on each watchdog tick; when count == `to_limit` (nonzero) it raises `expire`, holds, and stops counting. `run` = (state == RECV).
- States:
  - IDLE: `reading`=0. Go WAIT when `enable`=1.
  - WAIT: first falling edge -> shift in data bit, bit count=1, clear `done`/`err`, go RECV.
  - RECV: `reading`=1; each falling edge shifts `ps2d` sample into position bitcount, bitcount++. At bitcount==11 go CHECK. `expire` -> `err`=1, `done`=1, go WAIT (partial bits left in `data`, unreceived bits 0).
  - CHECK (one cycle): `err` = (start!=0) | (stop!=1) | (XOR of byte and parity != 1); `done`=1; go WAIT.
- `enable`=0 in any state: next cycle state IDLE, `reading`=0, `done`=0, `err`=0, `data` retained.
- `data` is written bit-by-bit during reception; the complete frame is valid whenever `done`=1.

## Timing
- Reset values: `reading`=0, `data`=0, `done`=0, `err`=0, state IDLE, all counters 0, both line-sample registers 1.
- Input-to-sample latency: 2 qzt_clk (sync) plus up to DIV_PERIOD cycles to the next tick.
- `done` rises exactly 2 qzt_clk after the tick that detects the 11th falling edge (1 to enter CHECK, 1 to register); `reading` falls on the same edge as `done` rises.
- `done`/`err` remain high until the next start edge, `enable`=0, or `rst`; consumers edge-detect `done`.
- Timeout: `expire` fires on the watchdog tick where count reaches `to_limit` since the last falling edge; `done`=`err`=1 one cycle later.
- `rst` has priority over everything; mid-frame reset discards the frame with no `done`.
- Falling edge and `expire` in the same cycle: edge wins (counter cleared, no error).
- Edges faster than 2 ticks apart are not guaranteed to be captured (Nyquist limit of the sampler).

## Test plan
- DIV_PERIOD=4, TO_PERIOD=8, enable=1: send frame for 0xFA, parity 1 (PS2C period 40 cycles) -> `data`=0x7F4, `done`=1, `err`=0, `reading` high from first edge until `done`.
- Same frame with parity 0 -> `data`=0x5F4, `done`=1, `err`=1.
- `to_limit`=3, stop PS2C high after 5 bits -> `done`=`err`=1 after 3 watchdog ticks (24 cycles ±8) from the last edge; `reading`=0.
- `to_limit`=0, stall mid-frame 10000 cycles then finish 0x00 frame (parity 1) -> no timeout, `data`=0x600, `err`=0.
- Drop `enable` after 4 bits -> next cycle `reading`=0, `done`=0; re-enable and send 0xAA (parity 1) -> `data`=0x754, `err`=0.
- Assert `rst` mid-frame -> all outputs 0 next cycle; no `done` until a new full frame.
